// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one fixed-latency single-port memory between the IF and
//             DM requesters. Optional IF anti-starvation via the macro
//             ARB_STARVE_GUARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t              state_q,     state_d;
    owner_t              owner_q,     owner_d;
    logic [3:0]          lat_q,       lat_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                if_wins;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_SAT = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    // A saturated count hands the next contested slot to IF.
    assign if_wins = if_req && (!dm_req || (starve_q == STARVE_SAT));

    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE && (if_req || dm_req)) begin
            if (if_wins) begin
                starve_d = 4'd0;
            end else if (if_req && (starve_q != STARVE_SAT)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign if_wins = if_req && !dm_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    state_d  = S_ACCESS;
                    lat_d    = LAT_INIT;
                    mem_en_d = 1'b1;
                    if (if_wins) begin
                        owner_d     = OWN_IF;
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                    end else begin
                        owner_d     = OWN_DM;
                        mem_addr_d  = dm_addr;
                        mem_we_d    = dm_we;
                        mem_wdata_d = dm_wdata;
                    end
                end
            end
            S_ACCESS: begin
                if (lat_q == 4'd0) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_DONE: begin
                // No arbitration here, so a held request is not served twice.
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            lat_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_gnt    = (state_q != S_IDLE) && (owner_q == OWN_IF);
    assign dm_gnt    = (state_q != S_IDLE) && (owner_q == OWN_DM);
    assign if_done   = (state_q == S_DONE) && (owner_q == OWN_IF);
    assign dm_done   = (state_q == S_DONE) && (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Scoreboard bench for mem_port_arbiter with a fixed-latency
//             memory model; honours ARB_STARVE_GUARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_done;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we  = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_gnt, dm_done;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        case (a)
            32'h0040_0000: return 32'h8C08_0004;
            32'h0040_0004: return 32'h2108_FFFF;
            32'h0040_0008: return 32'h2402_0001;
            32'h1001_0010: return 32'h0BAD_F00D;
            32'h1001_0020: return 32'h55AA_55AA;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Memory model: read data is valid only in the cycle ending MEM_LAT
    // edges after the mem_en edge; any other cycle shows junk.
    int          age = 100;
    logic [31:0] m_addr = '0;
    logic        m_we = 1'b0;
    always @(negedge clk) begin
        if (mem_en) begin
            age    = 0;
            m_addr = mem_addr;
            m_we   = mem_we;
        end else if (age < 100) begin
            age = age + 1;
        end
        mem_rdata = (age == LAT - 1 && !m_we) ? rd_val(m_addr) : 32'hDEAD_D00D;
    end

    typedef struct {
        bit          dm;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        int          gap;
    } acc_t;

    typedef struct {
        bit          dm;
        logic [31:0] if_rd;
        logic [31:0] dm_rd;
    } done_t;

    acc_t        acc_q[$];
    done_t       done_q[$];
    logic [31:0] exp_if_rd = '0;
    logic [31:0] exp_dm_rd = '0;
    int          checks = 0;
    int          errors = 0;
    int          last_en = 0;

    task automatic expect_access(input bit dm, input logic [31:0] addr, input bit we,
                                 input logic [31:0] wdata, input int gap, input bit with_done);
        acc_t  a;
        done_t d;
        a.dm = dm; a.addr = addr; a.we = we; a.wdata = wdata; a.gap = gap;
        acc_q.push_back(a);
        if (with_done) begin
            if (!dm)      exp_if_rd = rd_val(addr);
            else if (!we) exp_dm_rd = rd_val(addr);
            d.dm = dm; d.if_rd = exp_if_rd; d.dm_rd = exp_dm_rd;
            done_q.push_back(d);
        end
    endtask

    task automatic mon_step();
        acc_t  a;
        done_t d;
        if (!rst_n) return;
        checks++;
        if (if_gnt && dm_gnt) begin
            errors++;
            $display("FAIL gnt_exclusive @%0d: if_gnt=%b dm_gnt=%b required not both", cyc, if_gnt, dm_gnt);
        end
        if (mem_en) begin
            checks++;
            if (acc_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_mem_en @%0d: addr=%h we=%b", cyc, mem_addr, mem_we);
            end else begin
                a = acc_q.pop_front();
                if ({mem_addr, mem_we, mem_wdata, dm_gnt, if_gnt} !== {a.addr, a.we, a.wdata, a.dm, !a.dm}) begin
                    errors++;
                    $display("FAIL access @%0d: got addr=%h we=%b wd=%h dg=%b ig=%b, required addr=%h we=%b wd=%h dg=%b ig=%b",
                             cyc, mem_addr, mem_we, mem_wdata, dm_gnt, if_gnt, a.addr, a.we, a.wdata, a.dm, !a.dm);
                end
                if (a.gap != 0) begin
                    checks++;
                    if (cyc - last_en != a.gap) begin
                        errors++;
                        $display("FAIL access_spacing @%0d: got %0d cycles, required %0d", cyc, cyc - last_en, a.gap);
                    end
                end
            end
            last_en = cyc;
        end
        if (if_done || dm_done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done @%0d: if_done=%b dm_done=%b", cyc, if_done, dm_done);
            end else begin
                d = done_q.pop_front();
                if ({if_done, dm_done, if_gnt, dm_gnt, if_rdata, dm_rdata} !==
                    {!d.dm, d.dm, !d.dm, d.dm, d.if_rd, d.dm_rd}) begin
                    errors++;
                    $display("FAIL done @%0d: got ido=%b ddo=%b ig=%b dg=%b ifr=%h dmr=%h, required ido=%b ddo=%b ifr=%h dmr=%h",
                             cyc, if_done, dm_done, if_gnt, dm_gnt, if_rdata, dm_rdata, !d.dm, d.dm, d.if_rd, d.dm_rd);
                end
                checks++;
                if (cyc - last_en != LAT) begin
                    errors++;
                    $display("FAIL done_latency @%0d: got %0d cycles after mem_en, required %0d", cyc, cyc - last_en, LAT);
                end
            end
        end
    endtask

    task automatic check_idle(input string name);
        logic [133:0] v;
        v = {if_gnt, if_rdata, if_done, dm_gnt, dm_rdata, dm_done, mem_en, mem_we, mem_addr, mem_wdata};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h required all zero", name, v);
        end
    endtask

    task automatic wait_done(input bit dm, input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dm ? dm_done : if_done) && n < maxc);
        if (!(dm ? dm_done : if_done)) begin
            checks++;
            errors++;
            $display("FAIL timeout_done_%s: no done within %0d cycles, required one", dm ? "dm" : "if", maxc);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // IF read only
        expect_access(1'b0, 32'h0040_0000, 1'b0, 32'h0, 0, 1'b1);
        if_addr = 32'h0040_0000;
        if_req  = 1'b1;
        wait_done(1'b0, 20);
        if_req  = 1'b0;
        repeat (2) @(negedge clk);

        // Simultaneous: DM write wins, IF follows MEM_LAT+2 later
        expect_access(1'b1, 32'h1001_0000, 1'b1, 32'hDEAD_BEEF, 0, 1'b1);
        expect_access(1'b0, 32'h0040_0004, 1'b0, 32'h0, LAT + 2, 1'b1);
        dm_addr = 32'h1001_0000; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1;
        if_addr = 32'h0040_0004;
        dm_req  = 1'b1;
        if_req  = 1'b1;
        fork
            begin wait_done(1'b1, 20); dm_req = 1'b0; end
            begin wait_done(1'b0, 30); if_req = 1'b0; end
        join
        dm_we = 1'b0; dm_wdata = '0;
        repeat (2) @(negedge clk);

        // Both held: grant order depends on the starvation guard
        for (int k = 0; k < 10; k++) begin
            if (GUARD && (k % (SMAX + 1) == SMAX))
                expect_access(1'b0, 32'h0040_0008, 1'b0, 32'h0, (k == 0) ? 0 : LAT + 2, 1'b1);
            else
                expect_access(1'b1, 32'h1001_0010, 1'b0, 32'h0, (k == 0) ? 0 : LAT + 2, 1'b1);
        end
        dm_addr = 32'h1001_0010;
        if_addr = 32'h0040_0008;
        dm_req  = 1'b1;
        if_req  = 1'b1;
        begin
            int ndone = 0;
            int n = 0;
            while (ndone < 10 && n < 10 * (LAT + 2) + 20) begin
                @(negedge clk);
                n++;
                if (if_done || dm_done) ndone++;
            end
            if (ndone < 10) begin
                checks++;
                errors++;
                $display("FAIL timeout_contention: got %0d completions, required 10", ndone);
            end
        end
        dm_req = 1'b0;
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during a DM read access; restart after release
        expect_access(1'b1, 32'h1001_0020, 1'b0, 32'h0, 0, 1'b0);
        exp_if_rd = '0;
        exp_dm_rd = '0;
        expect_access(1'b1, 32'h1001_0020, 1'b0, 32'h0, 0, 1'b1);
        dm_addr = 32'h1001_0020;
        dm_req  = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mem_en && n < 20);
            if (!mem_en) begin
                checks++;
                errors++;
                $display("FAIL timeout_mem_en: no mem_en within 20 cycles, required one");
            end
        end
        #2 rst_n = 1'b0;
        #1 check_idle("reset_mid_access");
        repeat (2) @(negedge clk);
        check_idle("reset_held");
        rst_n = 1'b1;
        wait_done(1'b1, 20);
        dm_req = 1'b0;
        repeat (2) @(negedge clk);

        // IF holds request across DONE with a new address
        expect_access(1'b0, 32'h0000_0100, 1'b0, 32'h0, 0, 1'b1);
        expect_access(1'b0, 32'h0000_0104, 1'b0, 32'h0, LAT + 2, 1'b1);
        if_addr = 32'h0000_0100;
        if_req  = 1'b1;
        wait_done(1'b0, 20);
        if_addr = 32'h0000_0104;
        wait_done(1'b0, 20);
        if_req  = 1'b0;

        repeat (10) @(negedge clk);
        checks++;
        if (acc_q.size() != 0) begin
            errors++;
            $display("FAIL access_queue_drain: %0d accesses outstanding, required 0", acc_q.size());
        end
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL done_queue_drain: %0d completions outstanding, required 0", done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
